// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the single main_mem slave port.
// Master 0 is the data side, master 1 the instruction fetch/DMA side.
// A watchdog aborts any granted transaction that main_mem never acknowledges.

module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_cyc,
    input  logic        m0_we,
    input  logic [3:0]  m0_strb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_cyc,
    input  logic        m1_we,
    input  logic [3:0]  m1_strb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        s_cyc,
    output logic        s_we,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] wdt;
    logic             wdt_expired;

    assign wdt_expired = (wdt == WDT_LAST);

    // Grant sequencing: pick a master in IDLE, run the watchdog while granted, force one release cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            wdt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdt <= '0;
                    if (m0_cyc && (!m1_cyc || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (s_ack || !m0_cyc || wdt_expired) begin
                        state <= REL;
                        wdt   <= '0;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
                end
                GNT1: begin
                    if (s_ack || !m1_cyc || wdt_expired) begin
                        state <= REL;
                        wdt   <= '0;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
                end
                REL: begin
                    state <= IDLE;
                    wdt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    wdt   <= '0;
                end
            endcase
        end
    end

    // Bus steering: connect only the granted master to main_mem, everyone else sees zeros.
    always_comb begin
        s_cyc     = 1'b0;
        s_we      = 1'b0;
        s_strb    = 4'h0;
        s_addr    = 32'h0;
        s_data_o  = 32'h0;
        m0_data_o = 32'h0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_data_o = 32'h0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        case (state)
            GNT0: begin
                s_cyc     = m0_cyc;
                s_we      = m0_we;
                s_strb    = m0_strb;
                s_addr    = m0_addr;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack    = s_ack;
                m0_err    = m0_cyc && !s_ack && wdt_expired;
            end
            GNT1: begin
                s_cyc     = m1_cyc;
                s_we      = m1_we;
                s_strb    = m1_strb;
                s_addr    = m1_addr;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack    = s_ack;
                m1_err    = m1_cyc && !s_ack && wdt_expired;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single main_mem slave port between master 0 (data side) and master 1 (instruction fetch/DMA side).
- Grants the bus per transaction with round-robin priority.
- Forwards the granted master's cycle, write, strobe, address and data to main_mem, and routes s_ack and read data back to that master only.
- A watchdog counter aborts any transaction that main_mem fails to acknowledge, and reports the abort as an error.

Parameters:
- TIMEOUT, 64, cycles in a grant state without s_ack before abort; legal range 2..255.
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- m0_cyc  input  1  master 0 cycle request, held until m0_ack or m0_err
- m0_we  input  1  master 0 write enable
- m0_strb  input  4  master 0 byte strobes
- m0_addr  input  32  master 0 address
- m0_data_i  input  32  master 0 write data
- m0_data_o  output  32  read data to master 0
- m0_ack  output  1  transaction-complete pulse to master 0
- m0_err  output  1  timeout-abort pulse to master 0
- m1_cyc, m1_we, m1_strb, m1_addr, m1_data_i, m1_data_o, m1_ack, m1_err: same as master 0, for master 1
- s_cyc  output  1  to main_mem s_cyc
- s_we  output  1  to main_mem s_we
- s_strb  output  4  to main_mem s_strb
- s_addr  output  32  to main_mem s_addr
- s_data_o  output  32  to main_mem s_data_i
- s_data_i  input  32  from main_mem s_data_o
- s_ack  input  1  from main_mem s_ack

Behaviour:
- States: IDLE, GNT0, GNT1, REL. State register, 1-bit last-grant pointer `last` and watchdog counter `wdt` are all registered.
- Reset (rst_n low at a clock edge): state=IDLE, last=1 (so master 0 wins the first tie), wdt=0. All outputs low: s_cyc, s_we, s_strb, s_addr, s_data_o, m*_ack, m*_err, m*_data_o.
  - Reset mid-transaction: s_cyc drops at the edge where reset is sampled; no ack or err is issued.
- IDLE:
  - only m0_cyc -> GNT0; only m1_cyc -> GNT1.
  - both high -> grant the master != last.
  - Set last to the granted index on this transition. wdt cleared.
- GNTx outputs (combinational, from state):
  - s_cyc = mx_cyc.
  - s_we/s_strb/s_addr/s_data_o = master x's signals.
  - mx_data_o = s_data_i.
  - mx_ack = s_ack.
  - The non-granted master sees ack=0, err=0, data_o=0.
  - Outside GNTx, all slave outputs are 0.
- GNTx transitions:
  - s_ack high -> REL.
  - else mx_cyc low (illegal early abandon) -> REL, no ack/err.
  - else wdt==TIMEOUT-1 -> REL with mx_err=1 in that cycle (combinational, one cycle); wdt cleared.
  - else wdt increments.
  - s_ack and timeout in the same cycle: ack wins, err stays 0.
- REL: exactly one cycle with s_cyc=0 so the memory controller FSM returns to idle; then -> IDLE. Requests are not sampled in REL.
- Latency: request seen in IDLE at edge N -> s_cyc high during cycle N+1. Minimum spacing between back-to-back transactions: ack cycle + REL + IDLE = 2 cycles of s_cyc low.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Masters must keep cyc/we/strb/addr/data stable from cyc rise until ack/err. The arbiter does not latch them.
- Ack and err are single-cycle pulses. A master may re-raise cyc in the cycle after its ack.

Test Plan:
- Reset then only m0_cyc=1, we=1, strb=4'hF, addr=32'h0000_0100, data=32'hDEADBEEF -> s_cyc high the cycle after IDLE sampling, s_addr=32'h100, m0_ack pulses with s_ack, m1_ack stays 0; REL cycle shows s_cyc=0.
- m1 read addr=32'h0000_0100 after the above -> m1_data_o=32'hDEADBEEF in the s_ack cycle, m0_data_o=0.
- m0 and m1 request in the same cycle from reset, held continuously for 4 transactions -> grant order 0,1,0,1; each ack goes only to the owning master.
- TIMEOUT=8, slave model never acks, m1 requests -> s_cyc high for exactly 8 cycles, m1_err single pulse in the 8th, then REL, then IDLE; m1_ack never high.
- s_ack asserted in the same cycle wdt reaches TIMEOUT-1 -> m0_ack=1, m0_err=0.
- rst_n driven low during GNT0 with m0_cyc held -> next edge s_cyc=0, state IDLE, no ack or err. After release, simultaneous requests grant master 0 first (last=1).
